// File: rtl/board_init_ctrl.sv
// Start-of-game board sequencer: requests a board from the generator, scans it for
// illegal codes or pre-existing 3-in-a-row runs, regenerates on failure, then hands it off.
module board_init_ctrl #(
  parameter int unsigned MAX_RETRY = 7,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned RW        = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          gen_fresh,
  input  logic          gen_done,
  input  logic [191:0]  gen_board,
  output logic [191:0]  board,
  output logic          board_valid,
  input  logic          board_ready,
  output logic          board_clean,
  output logic [RW-1:0] retries
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] MaxRetryW = RW'(MAX_RETRY);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StScan, StDone} state_e;

  state_e        state_q;
  logic [5:0]    idx_q;
  logic [TW-1:0] tmo_q;

  logic [2:0] cells [64];
  logic [2:0] row, col;
  logic [2:0] c0, c1, c2, d1, d2;
  logic       bad_code, h_run, v_run, fault;
  logic       tmo_hit, retry_evt, give_up;

  always_comb begin
    for (int k = 0; k < 64; k++) begin
      cells[k] = board[k*3 +: 3];
    end
  end

  // Neighbour indices wrap at 63; the row/column guards mask those cases out.
  always_comb begin
    row      = idx_q[5:3];
    col      = idx_q[2:0];
    c0       = cells[idx_q];
    c1       = cells[idx_q + 6'd1];
    c2       = cells[idx_q + 6'd2];
    d1       = cells[idx_q + 6'd8];
    d2       = cells[idx_q + 6'd16];
    bad_code = (c0 == 3'd0) || (c0 > 3'd5);
    h_run    = (col <= 3'd5) && (c0 == c1) && (c0 == c2);
    v_run    = (row <= 3'd5) && (c0 == d1) && (c0 == d2);
    fault    = bad_code || h_run || v_run;
  end

  always_comb begin
    tmo_hit   = (tmo_q == TmoLast);
    retry_evt = ((state_q == StWait) && !gen_done && tmo_hit) ||
                ((state_q == StScan) && fault);
    give_up   = (retries >= MaxRetryW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      gen_fresh   <= 1'b0;
      board_valid <= 1'b0;
      board_clean <= 1'b0;
      board       <= '0;
      retries     <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
    end else begin
      gen_fresh <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StReq;
            busy      <= 1'b1;
            gen_fresh <= 1'b1;
            retries   <= '0;
          end
        end
        StReq: begin
          state_q <= StWait;
          tmo_q   <= '0;
        end
        StWait: begin
          if (gen_done) begin
            board   <= gen_board;
            idx_q   <= '0;
            state_q <= StScan;
          end else if (!tmo_hit) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StScan: begin
          if (!fault) begin
            if (idx_q == 6'd63) begin
              board_clean <= 1'b1;
              board_valid <= 1'b1;
              state_q     <= StDone;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        StDone: begin
          if (board_ready) begin
            board_valid <= 1'b0;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Shared by generator timeout and scan fault; a timeout leaves board untouched.
      if (retry_evt) begin
        if (!give_up) begin
          retries   <= retries + 1'b1;
          gen_fresh <= 1'b1;
          state_q   <= StReq;
        end else begin
          board_clean <= 1'b0;
          board_valid <= 1'b1;
          state_q     <= StDone;
        end
      end
    end
  end

endmodule
